// File: rtl/pc_next_unit_pkg.sv
// pc_pkg: shared widths, increment and next-PC source encoding for the
// next-program-counter unit of the single-cycle 32-bit MIPS core.
//
// Contents:
//   PC_W, IMM_W, JADDR_W : widths of the PC, sign-extended immediate and jump field
//   PC_INCR              : sequential fetch stride in bytes
//   npc_src_e            : which path produced the next PC (sequential/branch/jump)
package pc_pkg;

  localparam int PC_W    = 32;
  localparam int IMM_W   = 32;
  localparam int JADDR_W = 26;

  localparam logic [PC_W-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_JMP = 2'd2
  } npc_src_e;

endpackage

// File: rtl/pc_next_unit_if.sv
// pc_next_if: bundles the control flags, operands and registered result of
// the next-PC unit so the core and the unit share one connection point.
//
// Signals:
//   Zero, Branch, BranchTest, Jump : ALU flag and decode controls
//   PC                             : current program counter
//   instruction1                   : sign-extended 16-bit word offset
//   instruction6                   : instruction[25:0] jump field
//   pc_next                        : registered next PC
//   misalign                       : registered misaligned-target flag
//                                    (only when PC_MISALIGN_FLAG_EN is defined)
//
// Modports:
//   master : the core side, drives operands and reads pc_next
//   slave  : the next-PC unit, reads operands and drives pc_next
interface pc_next_if;
  import pc_pkg::*;

  logic               Zero;
  logic               Branch;
  logic               BranchTest;
  logic               Jump;
  logic [PC_W-1:0]    PC;
  logic [IMM_W-1:0]   instruction1;
  logic [JADDR_W-1:0] instruction6;
  logic [PC_W-1:0]    pc_next;
`ifdef PC_MISALIGN_FLAG_EN
  logic               misalign;
`endif

  modport master (
    output Zero, Branch, BranchTest, Jump, PC, instruction1, instruction6,
`ifdef PC_MISALIGN_FLAG_EN
    input  misalign,
`endif
    input  pc_next
  );

  modport slave (
    input  Zero, Branch, BranchTest, Jump, PC, instruction1, instruction6,
`ifdef PC_MISALIGN_FLAG_EN
    output misalign,
`endif
    output pc_next
  );

endinterface

// File: rtl/pc_next_unit_sel.sv
// pc_next_sel: purely combinational next-PC target computation and
// priority selection (jump over taken branch over sequential).
//
// Ports:
//   PC, instruction1, instruction6 : current PC, word offset, jump field
//   Zero, Branch, BranchTest, Jump : flag and controls
//   sel_addr                       : selected next fetch address
//   sel_src                        : which path was selected
module pc_next_sel
  import pc_pkg::*;
(
  input  logic [PC_W-1:0]    PC,
  input  logic [IMM_W-1:0]   instruction1,
  input  logic [JADDR_W-1:0] instruction6,
  input  logic               Zero,
  input  logic               Branch,
  input  logic               BranchTest,
  input  logic               Jump,
  output logic [PC_W-1:0]    sel_addr,
  output npc_src_e           sel_src
);

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] j_target;
  logic            take;

  assign pc_plus4 = PC + PC_INCR;

  // Shifting in the full 32-bit width drops the two top bits of the offset,
  // which keeps all arithmetic modulo 2^32.
  assign br_target = pc_plus4 + (instruction1 << 2);

  // Region bits come from pc_plus4, so a jump in the last word of a 256 MB
  // region lands in the following region.
  assign j_target = {pc_plus4[PC_W-1:PC_W-4], instruction6, 2'b00};

  // BranchTest flips the sense of Zero: beq when 0, bne when 1.
  assign take = Branch & (Zero ^ BranchTest);

  always_comb begin
    sel_addr = pc_plus4;
    sel_src  = NPC_SEQ;
    if (Jump) begin
      sel_addr = j_target;
      sel_src  = NPC_JMP;
    end else if (take) begin
      sel_addr = br_target;
      sel_src  = NPC_BR;
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: registers the next fetch address of the single-cycle MIPS
// core. Target computation lives in pc_next_sel; this level adds the
// register, the synchronous reset and the optional misalignment flag.
//
// Parameters:
//   RESET_VECTOR : value loaded into pc_next while reset is high
//
// Ports:
//   clk   : system clock, all updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : pc_next_if.slave (operands in, pc_next out)
//
// Optional feature (macro PC_MISALIGN_FLAG_EN):
//   bus.misalign is registered alongside pc_next and is set when the selected
//   next address has nonzero bits [1:0]; it clears on reset.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input logic     clk,
  input logic     reset,
  pc_next_if.slave bus
);

  logic [PC_W-1:0] sel_addr;
  npc_src_e        sel_src;

  pc_next_sel u_sel (
    .PC           (bus.PC),
    .instruction1 (bus.instruction1),
    .instruction6 (bus.instruction6),
    .Zero         (bus.Zero),
    .Branch       (bus.Branch),
    .BranchTest   (bus.BranchTest),
    .Jump         (bus.Jump),
    .sel_addr     (sel_addr),
    .sel_src      (sel_src)
  );

  // A jump target is built with two zero low bits, so it can never be
  // misaligned whatever the PC was.
  always_comb begin
    assert (sel_src != NPC_JMP || sel_addr[1:0] == 2'b00);
  end

  // Reset dominates every control input.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pc_next <= RESET_VECTOR;
    end else begin
      bus.pc_next <= sel_addr;
    end
  end

`ifdef PC_MISALIGN_FLAG_EN
  // Only a misaligned PC input can lead here, via the sequential or branch path.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.misalign <= 1'b0;
    end else begin
      bus.misalign <= |sel_addr[1:0];
    end
  end
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: self-checking bench for pc_next_unit. Directed cases
// cover reset, beq/bne, jump priority, wrap-around and region crossing and a
// mid-run reset; a randomized phase compares against a behavioural model.
// Checks the misalign flag too when PC_MISALIGN_FLAG_EN is defined.
module tb_pc_next_unit;

  logic clk;
  logic reset;

  int n_compared;
  int n_mismatched;

  logic [31:0] exp_pc;
`ifdef PC_MISALIGN_FLAG_EN
  logic        exp_mis;
`endif

  pc_next_if bus ();

  pc_next_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: next PC written from the architectural rules.
  function automatic logic [31:0] ref_next(
    input logic [31:0] pc, input logic [31:0] imm, input logic [25:0] j26,
    input logic zero, input logic br, input logic bt, input logic jmp);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (jmp) return (seq & 32'hF000_0000) + (32'(j26) * 32'd4);
    if (br && (zero != bt)) return seq + imm * 32'd4;
    return seq;
  endfunction

  // Drives one set of inputs, computes the expected result, then clocks.
  task automatic applyStimulus(
    input logic rst, input logic [31:0] pc, input logic [31:0] imm,
    input logic [25:0] j26, input logic zero, input logic br,
    input logic bt, input logic jmp);
    logic [31:0] nxt;
    reset            = rst;
    bus.PC           = pc;
    bus.instruction1 = imm;
    bus.instruction6 = j26;
    bus.Zero         = zero;
    bus.Branch       = br;
    bus.BranchTest   = bt;
    bus.Jump         = jmp;
    nxt    = ref_next(pc, imm, j26, zero, br, bt, jmp);
    exp_pc = rst ? 32'h0 : nxt;
`ifdef PC_MISALIGN_FLAG_EN
    exp_mis = rst ? 1'b0 : (nxt[1:0] != 2'b00);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expected);
    n_compared++;
    assert (bus.pc_next === expected)
    else begin
      n_mismatched++;
      $error("FAIL %s: observed pc_next=%h expected %h", tag, bus.pc_next, expected);
    end
`ifdef PC_MISALIGN_FLAG_EN
    n_compared++;
    assert (bus.misalign === exp_mis)
    else begin
      n_mismatched++;
      $error("FAIL %s_misalign: observed %b expected %b", tag, bus.misalign, exp_mis);
    end
`endif
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] r;
    logic [15:0] imm16;
    logic [25:0] j26;
    n_compared   = 0;
    n_mismatched = 0;
    #2;

    $display("[TB] directed phase");
    applyStimulus(1'b1, 32'h1234_5678, 32'h0000_0055, 26'h3AB_CDEF, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("reset", 32'h0);

    applyStimulus(1'b0, 32'h4, 32'h2, 26'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("beq_not_taken", 32'h8);

    applyStimulus(1'b0, 32'h4, 32'h2, 26'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("beq_taken", 32'h10);

    applyStimulus(1'b0, 32'h4, 32'h2, 26'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("bne_not_taken", 32'h8);

    applyStimulus(1'b0, 32'h100, 32'hFFFF_FFFE, 26'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("bne_backward", 32'h0FC);

    applyStimulus(1'b0, 32'h1000_0000, 32'h7, 26'h000_0040, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("jump_priority", 32'h1000_0100);

    applyStimulus(1'b0, 32'hFFFF_FFFC, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("seq_wrap", 32'h0);

    applyStimulus(1'b0, 32'h0FFF_FFFC, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("jump_region", 32'h1000_0000);

    applyStimulus(1'b0, 32'h4, 32'h2, 26'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("preload_0x10", 32'h10);

    applyStimulus(1'b1, 32'h4, 32'h2, 26'h155_5555, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("midrun_reset", 32'h0);

    applyStimulus(1'b0, 32'h20, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("after_reset", 32'h24);

    $display("[TB] random phase");
    for (int i = 0; i < 200; i++) begin
      pc = $urandom;
      if ($urandom_range(0, 7) != 0) pc = pc & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC - 32'($urandom_range(0, 3) * 4);
      imm16 = 16'($urandom);
      imm   = {{16{imm16[15]}}, imm16};
      j26   = 26'($urandom);
      r     = $urandom;
      applyStimulus(($urandom_range(0, 19) == 0), pc, imm, j26,
                    r[0], r[1], r[2], (r[4:3] == 2'b00));
      checkOutput($sformatf("random_%0d", i), exp_pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Next-program-counter unit for the single-cycle, non-pipelined 32-bit MIPS core.
- Takes the current PC, the sign-extended branch immediate, the 26-bit jump field and the control/ALU flags.
- Computes the next fetch address (sequential, branch-taken or jump) and holds it in a register that feeds the PC.

Parameters:
- RESET_VECTOR, 32'h0000_0000, value loaded into pc_next while reset is high.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Zero  input  1  ALU zero flag from the current instruction's compare.
- Branch  input  1  control: current instruction is a conditional branch.
- BranchTest  input  1  branch sense: 0 = beq (taken when Zero=1), 1 = bne (taken when Zero=0).
- Jump  input  1  control: current instruction is j/jal.
- PC  input  32  current program counter.
- instruction1  input  32  sign-extended 16-bit immediate (word offset).
- instruction6  input  26  instruction[25:0] jump target field.
- pc_next  output  32  registered next PC.

Behaviour:
- Combinational terms, all modulo 2^32 with no overflow detection:
  - pc_plus4 = PC + 32'd4.
  - br_target = pc_plus4 + (instruction1 << 2), discarding the top 2 shifted-out bits.
  - j_target = {pc_plus4[31:28], instruction6, 2'b00}.
- Branch taken: take = Branch & (Zero ^ BranchTest).
- Selection priority: Jump, then take, then pc_plus4.
  - Jump=1 selects j_target regardless of Branch/Zero.
  - Otherwise take=1 selects br_target.
  - Otherwise pc_plus4 is selected.
- Register:
  - On a rising clk edge with reset=1: pc_next <= RESET_VECTOR.
  - On a rising clk edge with reset=0: pc_next <= the selected value.
  - pc_next holds its value between edges.
- Latency: one clock from input change to pc_next update. No handshake; inputs are sampled every edge.
- Reset dominates every control input. Asserting reset mid-program forces RESET_VECTOR on the next edge.
- Before the first edge with reset high, the output value is don't-care.
- Boundary cases:
  - PC=32'hFFFF_FFFC wraps to 0 on the sequential path.
  - A negative immediate (instruction1[31]=1) produces a backward branch.
  - The jump region bits come from pc_plus4, not PC. PC=32'h0FFF_FFFC therefore jumps into the 32'h1xxx_xxxx region.
- No internal state other than the pc_next register.

Optional Feature:
- Macro PC_MISALIGN_FLAG_EN.
- When defined:
  - Extra output port misalign (1 bit), registered alongside pc_next.
  - misalign is set to 1 when the selected next value has bits [1:0] != 0; this is only possible from a misaligned PC input.
  - misalign clears to 0 on reset.
- When undefined: the port and its logic are absent, and the block behaves exactly as above.

Decomposition:
- Shared package pc_pkg holds:
  - localparam PC_W=32, IMM_W=32, JADDR_W=26.
  - localparam PC_INCR=4.
  - An enum for the next-PC source: NPC_SEQ, NPC_BR, NPC_JMP.
- One natural sub-module: pc_next_sel.
  - Purely combinational target computation plus priority mux.
  - Outputs the selected address and the source enum.
- The top level pc_next_unit adds only the register, the reset and the optional flag.

Test Plan:
- Reset: hold reset=1 for one edge with arbitrary inputs -> pc_next=32'h0. Release, then PC=4, imm=2, Branch=1, Zero=0, BranchTest=0 -> next edge pc_next=32'h8 (beq not taken).
- beq taken: PC=4, imm=2, Branch=1, Zero=1, BranchTest=0 -> pc_next=32'h10. Same inputs with BranchTest=1 -> 32'h8.
- bne taken: PC=32'h100, imm=32'hFFFF_FFFE, Branch=1, Zero=0, BranchTest=1 -> pc_next=32'h0FC (backward branch).
- Jump priority: PC=32'h1000_0000, instruction6=26'h000_0040, Jump=1, Branch=1, Zero=1 -> pc_next=32'h1000_0100.
- Wrap and region: PC=32'hFFFF_FFFC, all controls 0 -> pc_next=0. PC=32'h0FFF_FFFC, Jump=1, instruction6=0 -> pc_next=32'h1000_0000.
- Mid-run reset: pc_next=32'h10 already loaded, assert reset for one edge with Jump=1 -> pc_next=32'h0, then resumes normal selection after release.
